// File: rtl/id_stage_ctrl_pkg.sv
// Shared core definitions for the decode stage: instruction/data types,
// the immediate-format enum and the decode bundle handed to execute.
package cpuDefine;

    localparam int XLEN_DEF = 32;

    typedef logic [31:0]         Instr;
    typedef logic [XLEN_DEF-1:0] DType;

    typedef enum logic [2:0] {
        NONE = 3'd0,
        I8   = 3'd1,
        I12  = 3'd2,
        I14  = 3'd3,
        I16  = 3'd4,
        I20  = 3'd5,
        I21  = 3'd6,
        I26  = 3'd7
    } Itype;

    typedef struct packed {
        Instr instr;
        DType pc;
        DType imm;
        Itype itype;
        logic unsign;
    } id_bundle_t;

    localparam id_bundle_t BUNDLE_RESET = '{
        instr:  '0,
        pc:     '0,
        imm:    '0,
        itype:  NONE,
        unsign: 1'b0
    };

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: assembles the immediate from the low 26 instruction
// bits according to the format code and the I12 unsigned-extend flag.
module imm_gen
    import cpuDefine::*;
(
    input  logic [25:0] i_instr,
    input  Itype        i_itype,
    input  logic        i_unsign,
    output DType        o_imm
);

    always_comb begin
        o_imm = '0;
        case (i_itype)
            I8:  o_imm = {27'b0, i_instr[14:10]};
            I12: o_imm = i_unsign ? {20'b0, i_instr[21:10]}
                                  : {{20{i_instr[21]}}, i_instr[21:10]};
            I14: o_imm = {{16{i_instr[23]}}, i_instr[23:10], 2'b00};
            I16: o_imm = {{14{i_instr[25]}}, i_instr[25:10], 2'b00};
            I20: o_imm = {i_instr[24:5], 12'b0};
            // Branch offsets: the high field sits in the low instruction bits.
            I21: o_imm = {{11{i_instr[4]}}, i_instr[4:0], i_instr[25:10]};
            I26: o_imm = {{4{i_instr[9]}}, i_instr[9:0], i_instr[25:10], 2'b00};
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/itype_classify.sv
// Combinational immediate-format classifier for LA32R instruction words.
// Only the opcode bits [31:15] take part in classification.
module itype_classify
    import cpuDefine::*;
(
    input  logic [31:15] i_op,
    output Itype         o_itype,
    output logic         o_unsign
);

    logic [9:0] w_op10;
    logic [6:0] w_op7;
    logic [7:0] w_op8;
    logic [5:0] w_op6;

    assign w_op10 = i_op[31:22];
    assign w_op7  = i_op[31:25];
    assign w_op8  = i_op[31:24];
    assign w_op6  = i_op[31:26];

    // The opcode groups are disjoint, so the chain order only affects timing.
    always_comb begin
        o_itype  = NONE;
        o_unsign = 1'b0;
        if (i_op inside {17'h00081, 17'h00089, 17'h00091}) begin
            o_itype = I8;
        end else if (w_op10 inside {10'h008, 10'h009, 10'h00A,
                                    [10'h0A0:10'h0A2], [10'h0A4:10'h0A6],
                                    10'h0A8, 10'h0A9}) begin
            o_itype = I12;
        end else if (w_op10 inside {10'h00D, 10'h00E, 10'h00F}) begin
            o_itype  = I12;
            o_unsign = 1'b1;
        end else if (w_op7 inside {7'h0A, 7'h0E}) begin
            o_itype = I20;
        end else if (w_op8 inside {8'h20, 8'h21}) begin
            o_itype = I14;
        end else if (w_op6 inside {6'h13, [6'h16:6'h1B]}) begin
            o_itype = I16;
        end else if (w_op6 inside {6'h10, 6'h11}) begin
            o_itype = I21;
        end else if (w_op6 inside {6'h14, 6'h15}) begin
            o_itype = I26;
        end
    end

endmodule

// File: rtl/id_stage_ctrl.sv
// LA32R decode-stage controller: classifies the fetched word, forms its
// immediate and registers the bundle toward execute via a main + skid buffer.
module id_stage_ctrl
    import cpuDefine::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [31:0]     ex_instr,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_imm,
    output logic [2:0]      ex_itype,
    output logic            ex_unsign
);

    Itype       w_itype;
    logic       w_unsign;
    DType       w_imm;
    id_bundle_t w_in;
    logic       w_accept;
    logic       w_m_free;

    id_bundle_t r_m;
    id_bundle_t r_s;
    logic       r_m_valid;
    logic       r_s_valid;

    itype_classify u_classify (
        .i_op     (if_instr[31:15]),
        .o_itype  (w_itype),
        .o_unsign (w_unsign)
    );

    imm_gen u_imm_gen (
        .i_instr  (if_instr[25:0]),
        .i_itype  (w_itype),
        .i_unsign (w_unsign),
        .o_imm    (w_imm)
    );

    always_comb begin
        w_in        = BUNDLE_RESET;
        w_in.instr  = if_instr;
        w_in.pc     = if_pc;
        w_in.imm    = w_imm;
        w_in.itype  = w_itype;
        w_in.unsign = w_unsign;
    end

    // id_ready comes straight off the skid valid flop, so there is no
    // combinational path from ex_ready back to fetch.
    assign id_ready = ~r_s_valid;
    assign w_accept = if_valid & id_ready;
    assign w_m_free = ~r_m_valid | ex_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m       <= BUNDLE_RESET;
            r_s       <= BUNDLE_RESET;
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (r_s_valid) begin
            // Fetch is held off while the skid is occupied, so only a drain can happen.
            if (w_m_free) begin
                r_m       <= r_s;
                r_m_valid <= 1'b1;
                r_s_valid <= 1'b0;
            end
        end else if (w_accept) begin
            if (w_m_free) begin
                r_m       <= w_in;
                r_m_valid <= 1'b1;
            end else begin
                r_s       <= w_in;
                r_s_valid <= 1'b1;
            end
        end else if (ex_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign ex_valid  = r_m_valid;
    assign ex_instr  = r_m.instr;
    assign ex_pc     = r_m.pc;
    assign ex_imm    = r_m.imm;
    assign ex_itype  = r_m.itype;
    assign ex_unsign = r_m.unsign;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Self-checking bench for id_stage_ctrl: a negedge monitor scores every
// execute transfer against bundles queued from a reference decode model.
module tb_id_stage_ctrl;

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_I8   = 3'd1;
    localparam logic [2:0] T_I12  = 3'd2;
    localparam logic [2:0] T_I14  = 3'd3;
    localparam logic [2:0] T_I16  = 3'd4;
    localparam logic [2:0] T_I20  = 3'd5;
    localparam logic [2:0] T_I21  = 3'd6;
    localparam logic [2:0] T_I26  = 3'd7;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  itype;
        logic        unsign;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_instr;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [2:0]  ex_itype;
    logic        ex_unsign;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    exp_t        mon_got;
    logic [31:0] pc_ctr = 32'h1C00_0000;

    id_stage_ctrl #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .if_pc     (if_pc),
        .id_ready  (id_ready),
        .flush     (flush),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_instr  (ex_instr),
        .ex_pc     (ex_pc),
        .ex_imm    (ex_imm),
        .ex_itype  (ex_itype),
        .ex_unsign (ex_unsign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t       r;
        logic [9:0] op10;
        logic [5:0] op6;
        r.instr  = ins;
        r.pc     = pc;
        r.imm    = 32'h0;
        r.itype  = T_NONE;
        r.unsign = 1'b0;
        op10 = ins[31:22];
        op6  = ins[31:26];
        if (ins[31:15] == 17'h00081 || ins[31:15] == 17'h00089 || ins[31:15] == 17'h00091) begin
            r.itype = T_I8;
            r.imm   = 32'(ins[14:10]);
        end else if ((op10 >= 10'h008 && op10 <= 10'h00A) ||
                     (op10 >= 10'h0A0 && op10 <= 10'h0A9 && op10 != 10'h0A3 && op10 != 10'h0A7)) begin
            r.itype = T_I12;
            r.imm   = 32'($signed(ins[21:10]));
        end else if (op10 >= 10'h00D && op10 <= 10'h00F) begin
            r.itype  = T_I12;
            r.unsign = 1'b1;
            r.imm    = 32'(ins[21:10]);
        end else if (ins[31:25] == 7'h0A || ins[31:25] == 7'h0E) begin
            r.itype = T_I20;
            r.imm   = {ins[24:5], 12'h000};
        end else if (ins[31:24] == 8'h20 || ins[31:24] == 8'h21) begin
            r.itype = T_I14;
            r.imm   = 32'($signed({ins[23:10], 2'b00}));
        end else if (op6 == 6'h13 || (op6 >= 6'h16 && op6 <= 6'h1B)) begin
            r.itype = T_I16;
            r.imm   = 32'($signed({ins[25:10], 2'b00}));
        end else if (op6 == 6'h10 || op6 == 6'h11) begin
            r.itype = T_I21;
            r.imm   = 32'($signed({ins[4:0], ins[25:10]}));
        end else if (op6 == 6'h14 || op6 == 6'h15) begin
            r.itype = T_I26;
            r.imm   = 32'($signed({ins[9:0], ins[25:10], 2'b00}));
        end
        return r;
    endfunction

    // Scoreboard: score the transfer first, then drop or queue the fetch side.
    always @(negedge clk) begin
        if (ex_valid === 1'b1 && ex_ready === 1'b1) begin
            n_checks++;
            mon_got = '{instr: ex_instr, pc: ex_pc, imm: ex_imm, itype: ex_itype, unsign: ex_unsign};
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected: got instr=%h pc=%h, expected no transfer", ex_instr, ex_pc);
            end else begin
                mon_e = sb.pop_front();
                if (mon_got !== mon_e) begin
                    n_errors++;
                    $display("FAIL sb_bundle: got instr=%h pc=%h imm=%h itype=%0d uns=%0b, expected instr=%h pc=%h imm=%h itype=%0d uns=%0b",
                             mon_got.instr, mon_got.pc, mon_got.imm, mon_got.itype, mon_got.unsign,
                             mon_e.instr, mon_e.pc, mon_e.imm, mon_e.itype, mon_e.unsign);
                end
            end
        end
        if (rst === 1'b1 || flush === 1'b1) begin
            sb.delete();
        end else if (if_valid === 1'b1 && id_ready === 1'b1) begin
            sb.push_back(model(if_instr, if_pc));
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] ins);
        if_valid = 1'b1;
        if_instr = ins;
        if_pc    = pc_ctr;
        pc_ctr   = pc_ctr + 32'd4;
    endtask

    task automatic wait_drain();
        if_valid = 1'b0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (sb.size() == 0 && ex_valid === 1'b0) break;
            tick();
        end
    endtask

    task automatic make_instr(input int k, output logic [31:0] ins);
        ins = $urandom();
        case (k % 20)
            0:  ins[31:15] = 17'h00081;
            1:  ins[31:15] = 17'h00089;
            2:  ins[31:15] = 17'h00091;
            3:  ins[31:22] = 10'h008;
            4:  ins[31:22] = 10'h00A;
            5:  ins[31:22] = 10'h0A0;
            6:  ins[31:22] = 10'h0A9;
            7:  ins[31:22] = 10'h0A3;
            8:  ins[31:22] = 10'h00F;
            9:  ins[31:25] = 7'h0A;
            10: ins[31:25] = 7'h0E;
            11: ins[31:24] = 8'h20;
            12: ins[31:26] = 6'h13;
            13: ins[31:26] = 6'h1B;
            14: ins[31:26] = 6'h10;
            15: ins[31:26] = 6'h14;
            16: ins[31:26] = 6'h16;
            17: ins[31:26] = 6'h12;
            18: ins[31:22] = 10'h00C;
            default: ins[31:24] = 8'h21;
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b1; if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b0;
        if_instr = 32'h0; if_pc = 32'h0;
        repeat (3) tick();
        n_checks++; if (ex_valid !== 1'b0) begin n_errors++; $display("FAIL reset_ex_valid: got %b expected 0", ex_valid); end
        n_checks++; if (id_ready !== 1'b1) begin n_errors++; $display("FAIL reset_id_ready: got %b expected 1", id_ready); end
        n_checks++; if (ex_instr !== 32'h0) begin n_errors++; $display("FAIL reset_ex_instr: got %h expected 0", ex_instr); end
        n_checks++; if (ex_pc !== 32'h0) begin n_errors++; $display("FAIL reset_ex_pc: got %h expected 0", ex_pc); end
        n_checks++; if (ex_imm !== 32'h0) begin n_errors++; $display("FAIL reset_ex_imm: got %h expected 0", ex_imm); end
        n_checks++; if (ex_itype !== T_NONE) begin n_errors++; $display("FAIL reset_ex_itype: got %0d expected 0", ex_itype); end
        n_checks++; if (ex_unsign !== 1'b0) begin n_errors++; $display("FAIL reset_ex_unsign: got %b expected 0", ex_unsign); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single(input string name, input logic [31:0] ins, input logic [2:0] it,
                               input logic un, input logic [31:0] imm);
        ex_ready = 1'b1;
        offer(ins);
        tick();
        if_valid = 1'b0;
        n_checks++; if (ex_valid !== 1'b1) begin n_errors++; $display("FAIL %s_valid: got %b expected 1", name, ex_valid); end
        n_checks++; if (ex_instr !== ins) begin n_errors++; $display("FAIL %s_instr: got %h expected %h", name, ex_instr, ins); end
        n_checks++; if (ex_itype !== it) begin n_errors++; $display("FAIL %s_itype: got %0d expected %0d", name, ex_itype, it); end
        n_checks++; if (ex_unsign !== un) begin n_errors++; $display("FAIL %s_unsign: got %b expected %b", name, ex_unsign, un); end
        n_checks++; if (ex_imm !== imm) begin n_errors++; $display("FAIL %s_imm: got %h expected %h", name, ex_imm, imm); end
        tick();
        n_checks++; if (ex_valid !== 1'b0) begin n_errors++; $display("FAIL %s_drained: got ex_valid=%b expected 0", name, ex_valid); end
    endtask

    task automatic test_classes();
        logic [31:0] ins;
        ex_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            make_instr(i, ins);
            offer(ins);
            n_checks++; if (id_ready !== 1'b1) begin n_errors++; $display("FAIL classes_id_ready[%0d]: got %b expected 1", i, id_ready); end
            if (i > 0) begin
                n_checks++; if (ex_valid !== 1'b1) begin n_errors++; $display("FAIL classes_ex_valid[%0d]: got %b expected 1", i, ex_valid); end
            end
            tick();
        end
        wait_drain();
        n_checks++; if (sb.size() != 0) begin n_errors++; $display("FAIL classes_pending: got %0d outstanding expected 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pend[4];
        logic        exp_rdy[6];
        logic        acc;
        int          sent;
        pend[0] = 32'h02BF_FC01; pend[1] = 32'h03BF_FC01;
        pend[2] = 32'h53FF_FFFF; pend[3] = 32'h1C00_0123;
        exp_rdy[0] = 1'b1; exp_rdy[1] = 1'b1; exp_rdy[2] = 1'b0;
        exp_rdy[3] = 1'b0; exp_rdy[4] = 1'b1; exp_rdy[5] = 1'b1;
        sent = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            ex_ready = (cyc >= 3);
            if (sent < 4) begin
                if_valid = 1'b1;
                if_instr = pend[sent];
                if_pc    = 32'h2000_0000 + 32'(sent * 4);
            end else begin
                if_valid = 1'b0;
            end
            if (cyc < 6) begin
                n_checks++;
                if (id_ready !== exp_rdy[cyc]) begin
                    n_errors++; $display("FAIL b2b_id_ready[%0d]: got %b expected %b", cyc, id_ready, exp_rdy[cyc]);
                end
            end
            if (cyc >= 1 && cyc <= 3) begin
                n_checks++;
                if (ex_valid !== 1'b1 || ex_instr !== pend[0]) begin
                    n_errors++; $display("FAIL b2b_stall_hold[%0d]: got valid=%b instr=%h expected valid=1 instr=%h", cyc, ex_valid, ex_instr, pend[0]);
                end
            end
            acc = if_valid & id_ready;
            tick();
            if (acc) sent++;
        end
        n_checks++; if (sent != 4) begin n_errors++; $display("FAIL b2b_accepted: got %0d expected 4", sent); end
        wait_drain();
        n_checks++; if (sb.size() != 0) begin n_errors++; $display("FAIL b2b_pending: got %0d outstanding expected 0", sb.size()); end
    endtask

    task automatic test_flush();
        ex_ready = 1'b0;
        offer(32'h0280_0401); tick();
        offer(32'h0380_0802); tick();
        flush = 1'b1;
        offer(32'h0280_0C03);
        n_checks++; if (id_ready !== 1'b0) begin n_errors++; $display("FAIL flush_full_id_ready: got %b expected 0", id_ready); end
        tick();
        flush = 1'b0; if_valid = 1'b0;
        n_checks++; if (ex_valid !== 1'b0) begin n_errors++; $display("FAIL flush_full_ex_valid: got %b expected 0", ex_valid); end
        n_checks++; if (id_ready !== 1'b1) begin n_errors++; $display("FAIL flush_full_id_ready_after: got %b expected 1", id_ready); end
        ex_ready = 1'b1;
        repeat (3) tick();
        n_checks++; if (ex_valid !== 1'b0) begin n_errors++; $display("FAIL flush_full_residue: got ex_valid=%b expected 0", ex_valid); end

        ex_ready = 1'b0;
        offer(32'h0280_1004); tick();
        flush = 1'b1;
        offer(32'h0280_1405);
        n_checks++; if (id_ready !== 1'b1) begin n_errors++; $display("FAIL flush_m_id_ready: got %b expected 1", id_ready); end
        tick();
        flush = 1'b0; if_valid = 1'b0;
        n_checks++; if (ex_valid !== 1'b0) begin n_errors++; $display("FAIL flush_m_dropped: got ex_valid=%b instr=%h expected 0", ex_valid, ex_instr); end
        wait_drain();
        n_checks++; if (sb.size() != 0) begin n_errors++; $display("FAIL flush_pending: got %0d outstanding expected 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        ex_ready = 1'b0;
        offer(32'h0280_2001); tick();
        offer(32'h5000_0010); tick();
        rst = 1'b1;
        offer(32'h0280_2402);
        tick();
        rst = 1'b0; if_valid = 1'b0;
        n_checks++; if (ex_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_ex_valid: got %b expected 0", ex_valid); end
        n_checks++; if (id_ready !== 1'b1) begin n_errors++; $display("FAIL rstmid_id_ready: got %b expected 1", id_ready); end
        n_checks++;
        if ({ex_instr, ex_pc, ex_imm, ex_itype, ex_unsign} !== '0) begin
            n_errors++; $display("FAIL rstmid_data: got instr=%h pc=%h imm=%h itype=%0d uns=%b expected all 0", ex_instr, ex_pc, ex_imm, ex_itype, ex_unsign);
        end
        ex_ready = 1'b1;
        offer(32'h02BF_FC01);
        tick();
        if_valid = 1'b0;
        n_checks++;
        if (ex_valid !== 1'b1 || ex_instr !== 32'h02BF_FC01) begin
            n_errors++; $display("FAIL rstmid_first: got valid=%b instr=%h expected valid=1 instr=02bffc01", ex_valid, ex_instr);
        end
        wait_drain();
        n_checks++; if (sb.size() != 0) begin n_errors++; $display("FAIL rstmid_pending: got %0d outstanding expected 0", sb.size()); end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        for (int i = 0; i < 400; i++) begin
            make_instr(int'($urandom_range(0, 39)), ins);
            if ($urandom_range(0, 3) != 0) offer(ins);
            else if_valid = 1'b0;
            ex_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 39) == 0);
            tick();
        end
        wait_drain();
        n_checks++; if (sb.size() != 0) begin n_errors++; $display("FAIL random_pending: got %0d outstanding expected 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_single("addi_w", 32'h02BF_FC01, T_I12, 1'b0, 32'hFFFF_FFFF);
        test_single("ori",    32'h03BF_FC01, T_I12, 1'b1, 32'h0000_0FFF);
        test_single("b",      32'h53FF_FFFF, T_I26, 1'b0, 32'hFFFF_FFFC);
        test_classes();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
